rr_arbiter: RTL
===============

// Module: rr_arbiter
// PURPOSE
//  Registered N-way arbiter. Picks one of PORTS requesters each cycle.
//  Modes: fixed priority or round-robin, optionally holding the grant until release.
//  Selection uses a masked priority-encode stage, so the grant is a clean
//  registered one-hot plus index. Shared-resource front end for DMA, bus and queue muxes.
// PARAMETERS
//  PORTS                 4   number of requesters, >=2
//  ARB_TYPE_ROUND_ROBIN  0   1 = round-robin, 0 = fixed priority
//  ARB_BLOCK             0   1 = hold grant until released, 0 = re-arbitrate every cycle
//  ARB_BLOCK_ACK         1   with ARB_BLOCK: 1 = release on acknowledge, 0 = release on request drop
//  ARB_LSB_HIGH_PRIORITY 0   1 = index 0 highest priority, 0 = index PORTS-1 highest
//  MAX_HOLD              16  hold-timeout limit in cycles (ARB_HOLD_TIMEOUT_EN only), >=1
// PORTS
//  clk            in   1             clock, rising edge
//  rst            in   1             asynchronous reset, active-high
//  request        in   PORTS         per-port request level
//  acknowledge    in   PORTS         per-port release strobe (ACK mode only)
//  grant          out  PORTS         registered one-hot grant
//  grant_valid    out  1             grant != 0
//  grant_encoded  out  max(1,clog2(PORTS))  index of granted port
//  hold_timeout   out  1             1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (async, any time including mid-hold):
//    - grant=0, grant_valid=0, grant_encoded=0, hold_timeout=0.
//    - rr mask = all-ones, hold counter=0, FSM=IDLE.
//  - FSM: IDLE (no grant) / HELD (grant live).
//    - IDLE->HELD on any request.
//    - HELD->HELD while hold continues.
//    - HELD->IDLE on release with no other request.
//  - Latency: request sampled at edge k, grant visible after edge k (1 cycle).
//  - Selection:
//    - Priority-encode (request & mask); if that is zero, encode request unmasked.
//    - Fixed mode: mask is all-ones.
//    - Round-robin, LSB priority: after granting g, mask = indices > g.
//    - Round-robin, MSB priority: after granting g, mask = indices < g.
//    - Wrap-around happens naturally via the unmasked fallback.
//  - ARB_BLOCK=0: grant recomputed every edge from the current request; grant tracks request.
//  - ARB_BLOCK=1, ARB_BLOCK_ACK=0:
//    - Grant held while request[g]=1.
//    - In the cycle request[g]=0, the next edge loads the new winner (no idle bubble).
//  - ARB_BLOCK=1, ARB_BLOCK_ACK=1:
//    - Grant held until acknowledge[g]=1; acknowledge on non-granted bits ignored.
//    - Next edge loads the new winner from the same-cycle request.
//  - Simultaneous release + re-request by g: in round-robin, g competes masked out.
//    It wins only if it is the sole requester.
//  - Request drop without ack in ACK mode: grant stays held until acknowledge.
//  - grant_valid and grant_encoded are always consistent with grant in the same cycle.
//  - Mask updates only on edges that load a new grant.
// CONFIGURATION
//  Macro ARB_HOLD_TIMEOUT_EN:
//  - Defined:
//    - A hold counter counts edges in HELD.
//    - On reaching MAX_HOLD, the grant is force-released and re-arbitrated at that edge.
//    - The rr mask advances past g; hold_timeout=1 for that cycle.
//    - The counter clears on every new grant.
//    - Applies only when ARB_BLOCK=1.
//  - Undefined: no counter logic; hold_timeout tied 0; hold unbounded.
// STRUCTURE
//  - Package arb_pkg:
//    - FSM state typedef (IDLE, HELD).
//    - Function clog2_min1(PORTS) for the index width.
//    - Function rr_mask(idx, lsb_hi) producing the next mask.
//  - Sub-module arb_pri_enc: combinational masked priority encoder.
//    - Parameters WIDTH, LSB_HIGH_PRIORITY.
//    - Outputs valid, index, one-hot.
//    - Two instances: masked and unmasked.
//  - Top holds the FSM, grant/mask registers and optional timeout counter.
// TESTING
//  1. Reset mid-hold: PORTS=4, ARB_BLOCK=1, grant=0010.
//     Assert rst async -> grant=0, grant_valid=0 immediately, no clk edge needed.
//  2. Fixed priority, MSB high: request=0101 -> grant=0100, grant_encoded=2 one cycle later.
//     Holds while request unchanged.
//  3. Round-robin, LSB high: request=1111 steady, ARB_BLOCK=0.
//     grant sequence 0001,0010,0100,1000,0001 (wrap).
//  4. Block+ack: grant=0001, request drops, no ack -> grant holds.
//     acknowledge=0001 with request=0100 -> grant=0100 next cycle, no idle bubble.
//  5. Block, no ack: request=0011, grant=0001.
//     Drop request[0] -> grant=0010 next edge; drop all -> grant_valid=0.
//  6. With ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4, request=0011 steady, round-robin.
//     grant 0001 held 4 edges, then hold_timeout pulse, grant=0010.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the rr_arbiter slice: FSM state, index width
// and the round-robin mask generator.
package arb_pkg;

    // Upper bound on PORTS supported by rr_mask().
    localparam int unsigned ARB_MAX_PORTS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Ports still eligible in the masked pass after granting idx.
    function automatic logic [ARB_MAX_PORTS-1:0] rr_mask(input int unsigned idx,
                                                         input logic lsb_hi);
        logic [ARB_MAX_PORTS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < ARB_MAX_PORTS; i++) begin
            m[i] = lsb_hi ? (i > idx) : (i < idx);
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and rr_arbiter (slave).
interface rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned PORTS = 4
);
    localparam int unsigned IDX_W = clog2_min1(PORTS);

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_encoded;
    logic             hold_timeout;

    modport master (
        output request, acknowledge,
        input  grant, grant_valid, grant_encoded, hold_timeout
    );

    modport slave (
        input  request, acknowledge,
        output grant, grant_valid, grant_encoded, hold_timeout
    );

endinterface

// File: rtl/arb_pri_enc.sv
// Combinational priority encoder: lowest or highest set bit wins, reported
// both as an index and as a one-hot vector.
module arb_pri_enc
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH             = 4,
    parameter bit          LSB_HIGH_PRIORITY = 1'b0,
    localparam int unsigned IDX_W            = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] request,
    output logic             valid,
    output logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        valid  = |request;
        index  = '0;
        onehot = '0;
        // Scan so that the highest-priority set bit is the last one written.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            int unsigned k;
            k = LSB_HIGH_PRIORITY ? (WIDTH - 1 - i) : i;
            if (request[k]) begin
                index     = IDX_W'(k);
                onehot    = '0;
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: fixed or round-robin priority, optional grant hold.
// Optional hold timeout is enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned PORTS                 = 4,
    parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b0,
    parameter bit          ARB_BLOCK             = 1'b0,
    parameter bit          ARB_BLOCK_ACK         = 1'b1,
    parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b0,
    parameter int unsigned MAX_HOLD              = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = clog2_min1(PORTS);

    arb_state_e       state;
    logic [PORTS-1:0] grant_r;
    logic [PORTS-1:0] mask_r;
    logic [IDX_W-1:0] idx_r;
    logic             valid_r;
    logic             timeout_r;

    logic [PORTS-1:0] masked_req;
    logic             m_valid, u_valid;
    logic [IDX_W-1:0] m_idx, u_idx;
    logic [PORTS-1:0] m_hot, u_hot;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [PORTS-1:0] win_hot;
    logic             rel;
    logic             timeout_hit;
    logic             load;

    assign masked_req = bus.request & mask_r;

    arb_pri_enc #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .request (masked_req),
        .valid   (m_valid),
        .index   (m_idx),
        .onehot  (m_hot)
    );

    arb_pri_enc #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_unmasked (
        .request (bus.request),
        .valid   (u_valid),
        .index   (u_idx),
        .onehot  (u_hot)
    );

    // Unmasked pass is the wrap-around when nothing remains above/below g.
    assign win_valid = u_valid;
    assign win_idx   = m_valid ? m_idx : u_idx;
    assign win_hot   = m_valid ? m_hot : u_hot;

    always_comb begin
        if (!ARB_BLOCK) begin
            rel = 1'b1;
        end else if (ARB_BLOCK_ACK) begin
            rel = |(bus.acknowledge & grant_r);
        end else begin
            rel = ~|(bus.request & grant_r);
        end
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt;

    assign timeout_hit = ARB_BLOCK && (state == HELD) && !rel &&
                         (hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (load) begin
            hold_cnt <= '0;
        end else if (state == HELD) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign load = (state == IDLE) || rel || timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_r   <= '0;
            idx_r     <= '0;
            valid_r   <= 1'b0;
            mask_r    <= '1;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_hit;
            if (load) begin
                state   <= win_valid ? HELD : IDLE;
                grant_r <= win_valid ? win_hot : '0;
                idx_r   <= win_valid ? win_idx : '0;
                valid_r <= win_valid;
                if (win_valid && ARB_TYPE_ROUND_ROBIN) begin
                    mask_r <= PORTS'(rr_mask(32'(win_idx), ARB_LSB_HIGH_PRIORITY));
                end
            end
        end
    end

    assign bus.grant         = grant_r;
    assign bus.grant_valid   = valid_r;
    assign bus.grant_encoded = idx_r;
    assign bus.hold_timeout  = timeout_r;

endmodule
